outsignal_deserializer: RTL and testbench
=========================================

# outsignal_deserializer

Receive-side endpoint for the processor's serial output line (`outSignal` with its forwarded clock `clkout`). It runs in the `clock` domain and synchronizes the external serial clock and data. It frames 8-bit characters (start bit, LSB-first data, optional parity, stop bit) and queues received bytes in a small FIFO. Consumers read the FIFO through a valid/ready handshake. It sits on the board/test side of the processor's I/O pins and gives the bench and the display logic a byte-level view of what the program emitted.

## Interface
- `FIFO_DEPTH`, 4: receive FIFO entries; must be a power of two, ≥2.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ser_clk`  in  1  external serial clock (driven from `clkout`); asynchronous to `clock`.
- `ser_data`  in  1  external serial data (driven from `outSignal`); idle high.
- `rx_data`  out  8  byte at FIFO head; 0 when empty.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts head byte.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupancy.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0.
- `parity_err`  out  1  one-cycle pulse: parity mismatch (tied 0 without `OUTSIG_PARITY_EN`).
- `overrun`  out  1  one-cycle pulse: completed byte dropped, FIFO full.

## Operation
- Both `ser_clk` and `ser_data` pass through identical 2-flop synchronizers. `ser_clk` sync flops reset to 0; `ser_data` sync flops reset to 1.
- A third flop on synchronized `ser_clk` drives a rising-edge detector, `tick`. `tick` is high for exactly one cycle per `ser_clk` rising edge.
- Data is sampled from the synchronized `ser_data` in the `tick` cycle only.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `tick` with sampled 0, go to DATA with bit counter = 0. A sampled 1 stays in IDLE.
  - DATA: on `tick`, shift the sample into bit[counter], LSB first. After the 8th bit, go to PARITY if `OUTSIG_PARITY_EN` is defined, otherwise go to STOP.
  - PARITY: on `tick`, compare the sample with even parity (XOR of the 8 data bits). A mismatch sets an internal flag. Then go to STOP.
  - STOP: on `tick`, the frame outcome is decided by the first matching rule below. In every case the FSM then returns to IDLE.
    - Sample 0: pulse `frame_err` and discard the byte.
    - Parity flag set: pulse `parity_err` and discard the byte.
    - Otherwise: push the byte.
- A new start bit is recognized only from IDLE. Back-to-back frames are legal: the `tick` after STOP may be a start bit.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(FIFO_DEPTH)+1 bits; the MSB distinguishes full from empty.
  - `rx_data` and `rx_valid` are driven from the head entry and count.
  - Pop when `rx_valid && rx_ready`.
  - Push when full and popping in the same cycle: both happen and the count is unchanged.
  - Push when full and not popping: the byte is dropped, `overrun` pulses, and FIFO contents are unchanged.
  - Pop when empty: ignored.
- Reset asserted at any time, including mid-frame:
  - FSM goes to IDLE, the partial byte is lost, and the FIFO is emptied.
  - Outputs: `rx_valid`=0, `rx_data`=0, `fifo_count`=0, `frame_err`=`parity_err`=`overrun`=0.
  - On release, reception resumes at the next start bit.

## Timing
- A `ser_clk` rising edge setting up before `clock` edge k raises `tick` in the cycle after edge k+1. The FSM acts on edge k+2.
- Byte push occurs on the same edge as the STOP→IDLE transition. `rx_valid` and `fifo_count` update on that edge.
- Input-pin-edge-to-`rx_valid` latency is 3 `clock` edges.
- Error pulses assert on the STOP→IDLE edge and last one cycle.
- `ser_clk` high and low phases must each be ≥3 `clock` periods.
- `ser_data` must be stable from 1 period before to 3 periods after each `ser_clk` rising edge. Violations give undefined data but never a hang.
- Pop takes effect on the `clock` edge where `rx_valid && rx_ready`. The next head appears on that edge.

## Configuration
- `OUTSIG_PARITY_EN` defined:
  - Frame is start + 8 data + even-parity bit + stop (11 `ser_clk` edges).
  - PARITY state is present and `parity_err` is live.
- `OUTSIG_PARITY_EN` undefined:
  - Frame is start + 8 data + stop (10 edges).
  - PARITY state is absent and `parity_err` is constant 0.

## Test plan
- Reset low then high with `ser_clk` = 8 clock periods. Send frame 0xA5 with `rx_ready`=0. Required: `rx_valid`=1, `rx_data`=0xA5, `fifo_count`=1, 3 edges after the stop-bit `ser_clk` rise. Then `rx_ready`=1 for one cycle gives `rx_valid`=0.
- Send frame 0x3C with stop bit 0. Required: one-cycle `frame_err`, `fifo_count` stays 0. A following good 0x11 frame is then received correctly.
- `FIFO_DEPTH`=4 with `rx_ready`=0: send 0x01..0x05 back-to-back. Required: `overrun` pulses once on the 5th frame. Reads return 0x01, 0x02, 0x03, 0x04, then `rx_valid`=0.
- FIFO full (0x01..0x04) with `rx_ready`=1 held exactly on the 5th frame's push edge. Required: no `overrun`, `fifo_count` stays 4, and the FIFO then drains 0x02..0x05.
- With `OUTSIG_PARITY_EN`: send 0x03 with parity bit 1. Required: `parity_err` pulse and no push. 0x07 with parity bit 1 is accepted as 0x07.
- Assert `reset` after 4 data bits of frame 0xFF, with FIFO holding 2 bytes. Required: `rx_valid`=0 and `fifo_count`=0 immediately (asynchronous). After release, frame 0x5A is received as 0x5A with no error pulses.

Source files
------------

// File: rtl/outsignal_deserializer.sv
// Serial receiver for the processor's outSignal/clkout pair: sync, frame, queue bytes for a valid/ready reader.
// Optional even-parity bit enabled by defining OUTSIG_PARITY_EN.
`timescale 1ns/1ps
module outsignal_deserializer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          ser_clk,
   input  logic                          ser_data,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overrun
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

`ifdef OUTSIG_PARITY_EN
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

   logic [2:0]    clk_sh_q, clk_sh_d;
   logic [1:0]    dat_sh_q, dat_sh_d;
   state_t        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          ferr_q, ferr_d;
   logic          ovr_q, ovr_d;
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [7:0]    mem_d [FIFO_DEPTH];
`ifdef OUTSIG_PARITY_EN
   logic          pflag_q, pflag_d;
   logic          perr_q, perr_d;
`endif

   logic tick, sample, byte_done, empty, full, push, pop;

   // Bit 2 of the clock shift register exists only to detect the synchronized rising edge.
   assign tick   = clk_sh_q[1] & ~clk_sh_q[2];
   assign sample = dat_sh_q[1];

   always_comb begin
      clk_sh_d  = {clk_sh_q[1:0], ser_clk};
      dat_sh_d  = {dat_sh_q[0], ser_data};
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      ferr_d    = 1'b0;
      byte_done = 1'b0;
`ifdef OUTSIG_PARITY_EN
      pflag_d   = pflag_q;
      perr_d    = 1'b0;
`endif
      if (tick) begin
         case (state_q)
            IDLE: begin
               if (!sample) begin
                  state_d = DATA;
                  cnt_d   = 3'd0;
`ifdef OUTSIG_PARITY_EN
                  pflag_d = 1'b0;
`endif
               end
            end
            DATA: begin
               shift_d[cnt_q] = sample;
               cnt_d          = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
`ifdef OUTSIG_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
`ifdef OUTSIG_PARITY_EN
            PARITY: begin
               if (sample != ^shift_q) pflag_d = 1'b1;
               state_d = STOP;
            end
`endif
            STOP: begin
               state_d = IDLE;
               if (!sample) begin
                  ferr_d = 1'b1;
`ifdef OUTSIG_PARITY_EN
               end else if (pflag_q) begin
                  perr_d = 1'b1;
`endif
               end else begin
                  byte_done = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // MSB of the pointers separates a full buffer from an empty one.
   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop   = !empty && rx_ready;
   assign push  = byte_done && (!full || pop);

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      ovr_d = byte_done && full && !pop;
      if (push) begin
         mem_d[wr_q[AW-1:0]] = shift_q;
         wr_d                = wr_q + PW'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         clk_sh_q <= 3'b000;
         dat_sh_q <= 2'b11;
         state_q  <= IDLE;
         cnt_q    <= 3'd0;
         shift_q  <= 8'h00;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
         wr_q     <= '0;
         rd_q     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
`ifdef OUTSIG_PARITY_EN
         pflag_q  <= 1'b0;
         perr_q   <= 1'b0;
`endif
      end else begin
         clk_sh_q <= clk_sh_d;
         dat_sh_q <= dat_sh_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         ferr_q   <= ferr_d;
         ovr_q    <= ovr_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         mem_q    <= mem_d;
`ifdef OUTSIG_PARITY_EN
         pflag_q  <= pflag_d;
         perr_q   <= perr_d;
`endif
      end
   end

   assign rx_valid   = !empty;
   assign rx_data    = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
   assign fifo_count = wr_q - rd_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;
`ifdef OUTSIG_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_outsignal_deserializer.sv
// Directed bench for outsignal_deserializer: framing, errors, FIFO full/overrun, async reset.
`timescale 1ns/1ps
module tb_outsignal_deserializer;

   logic       clock = 1'b0;
   logic       reset, ser_clk, ser_data, rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, parity_err, overrun;
   logic [2:0] fifo_count;

   int checks = 0, failures = 0;
   int n_ferr = 0, n_perr = 0, n_ovr = 0;

   logic       ev_valid [1:4];
   logic [7:0] ev_data  [1:4];
   logic [2:0] ev_cnt   [1:4];
   logic       ev_ferr  [1:4];
   logic       ev_perr  [1:4];
   logic       ev_ovr   [1:4];
`ifdef OUTSIG_PARITY_EN
   logic       par_force = 1'b0;
   logic       par_val   = 1'b0;
`endif

   outsignal_deserializer #(.FIFO_DEPTH(4)) dut (
      .clock(clock), .reset(reset), .ser_clk(ser_clk), .ser_data(ser_data),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .fifo_count(fifo_count), .frame_err(frame_err), .parity_err(parity_err),
      .overrun(overrun)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (frame_err)  n_ferr++;
      if (parity_err) n_perr++;
      if (overrun)    n_ovr++;
   end

   // One ser_clk period of 8 clock cycles; data changes with the falling ser_clk edge.
   task automatic send_bit(input logic b);
      ser_clk  = 1'b0;
      ser_data = b;
      repeat (4) @(negedge clock);
      ser_clk = 1'b1;
      repeat (4) @(negedge clock);
   endtask

   // Stop bit: record outputs 1..4 clock edges after its ser_clk rise.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop_at_push);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef OUTSIG_PARITY_EN
      send_bit(par_force ? par_val : ^b);
`endif
      ser_clk  = 1'b0;
      ser_data = stop;
      repeat (4) @(negedge clock);
      ser_clk = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         if (i == 3 && pop_at_push) rx_ready = 1'b1;
         @(posedge clock);
         #1;
         ev_valid[i] = rx_valid;   ev_data[i] = rx_data;   ev_cnt[i] = fifo_count;
         ev_ferr[i]  = frame_err;  ev_perr[i] = parity_err; ev_ovr[i] = overrun;
         rx_ready = 1'b0;
      end
   endtask

   task automatic read_expect(input logic [7:0] exp);
      @(negedge clock);
      checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL read_valid got=%b exp=1", rx_valid); end
      checks++; if (rx_data !== exp) begin failures++; $display("FAIL read_data got=%h exp=%h", rx_data, exp); end
      rx_ready = 1'b1;
      @(posedge clock);
      #1;
      rx_ready = 1'b0;
   endtask

   task automatic expect_empty();
      @(negedge clock);
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL empty_valid got=%b exp=0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL empty_data got=%h exp=00", rx_data); end
      checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL empty_count got=%0d exp=0", fifo_count); end
   endtask

   task automatic test_reset();
      reset = 1'b0; ser_clk = 1'b0; ser_data = 1'b1; rx_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", rx_data); end
      checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
      checks++; if ({frame_err, parity_err, overrun} !== 3'b000) begin
         failures++; $display("FAIL rst_pulses got=%b exp=000", {frame_err, parity_err, overrun}); end
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_basic();
      send_frame(8'hA5, 1'b1, 1'b0);
      checks++; if (ev_valid[2] !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", ev_valid[2]); end
      checks++; if (ev_valid[3] !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", ev_valid[3]); end
      checks++; if (ev_data[3] !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", ev_data[3]); end
      checks++; if (ev_cnt[3] !== 3'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", ev_cnt[3]); end
      @(negedge clock);
      rx_ready = 1'b1;
      @(posedge clock);
      #1;
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL basic_pop_valid got=%b exp=0", rx_valid); end
      rx_ready = 1'b0;
   endtask

   task automatic test_frame_err();
      send_frame(8'h3C, 1'b0, 1'b0);
      checks++; if (ev_ferr[2] !== 1'b0) begin failures++; $display("FAIL ferr_early got=%b exp=0", ev_ferr[2]); end
      checks++; if (ev_ferr[3] !== 1'b1) begin failures++; $display("FAIL ferr_pulse got=%b exp=1", ev_ferr[3]); end
      checks++; if (ev_ferr[4] !== 1'b0) begin failures++; $display("FAIL ferr_width got=%b exp=0", ev_ferr[4]); end
      checks++; if (ev_cnt[4] !== 3'd0) begin failures++; $display("FAIL ferr_count got=%0d exp=0", ev_cnt[4]); end
      send_frame(8'h11, 1'b1, 1'b0);
      checks++; if (ev_ferr[3] !== 1'b0) begin failures++; $display("FAIL ferr_next_pulse got=%b exp=0", ev_ferr[3]); end
      checks++; if (ev_data[3] !== 8'h11) begin failures++; $display("FAIL ferr_next_data got=%h exp=11", ev_data[3]); end
      read_expect(8'h11);
      expect_empty();
   endtask

   task automatic test_overrun();
      int o0;
      o0 = n_ovr;
      for (int k = 1; k <= 5; k++) begin
         send_frame(8'(k), 1'b1, 1'b0);
         if (k == 4) begin
            checks++; if (ev_ovr[3] !== 1'b0) begin failures++; $display("FAIL ovr_fill_pulse got=%b exp=0", ev_ovr[3]); end
         end
      end
      checks++; if (ev_ovr[3] !== 1'b1) begin failures++; $display("FAIL ovr_pulse got=%b exp=1", ev_ovr[3]); end
      checks++; if (ev_ovr[4] !== 1'b0) begin failures++; $display("FAIL ovr_width got=%b exp=0", ev_ovr[4]); end
      checks++; if (ev_cnt[3] !== 3'd4) begin failures++; $display("FAIL ovr_count got=%0d exp=4", ev_cnt[3]); end
      checks++; if (n_ovr - o0 !== 1) begin failures++; $display("FAIL ovr_total got=%0d exp=1", n_ovr - o0); end
      for (int k = 1; k <= 4; k++) read_expect(8'(k));
      expect_empty();
   endtask

   task automatic test_back_to_back();
      int o0;
      o0 = n_ovr;
      for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, 1'b0);
      send_frame(8'h05, 1'b1, 1'b1);
      checks++; if (ev_ovr[3] !== 1'b0) begin failures++; $display("FAIL b2b_ovr got=%b exp=0", ev_ovr[3]); end
      checks++; if (ev_cnt[3] !== 3'd4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", ev_cnt[3]); end
      checks++; if (ev_data[3] !== 8'h02) begin failures++; $display("FAIL b2b_head got=%h exp=02", ev_data[3]); end
      checks++; if (n_ovr - o0 !== 0) begin failures++; $display("FAIL b2b_ovr_total got=%0d exp=0", n_ovr - o0); end
      for (int k = 2; k <= 5; k++) read_expect(8'(k));
      expect_empty();
   endtask

   task automatic test_parity();
`ifdef OUTSIG_PARITY_EN
      par_force = 1'b1; par_val = 1'b1;
      send_frame(8'h03, 1'b1, 1'b0);
      checks++; if (ev_perr[3] !== 1'b1) begin failures++; $display("FAIL par_pulse got=%b exp=1", ev_perr[3]); end
      checks++; if (ev_perr[4] !== 1'b0) begin failures++; $display("FAIL par_width got=%b exp=0", ev_perr[4]); end
      checks++; if (ev_cnt[4] !== 3'd0) begin failures++; $display("FAIL par_count got=%0d exp=0", ev_cnt[4]); end
      send_frame(8'h07, 1'b1, 1'b0);
      checks++; if (ev_perr[3] !== 1'b0) begin failures++; $display("FAIL par_ok_pulse got=%b exp=0", ev_perr[3]); end
      checks++; if (ev_data[3] !== 8'h07) begin failures++; $display("FAIL par_ok_data got=%h exp=07", ev_data[3]); end
      par_force = 1'b0;
      read_expect(8'h07);
      expect_empty();
`else
      checks++; if (n_perr !== 0) begin failures++; $display("FAIL par_tied got=%0d exp=0", n_perr); end
`endif
   endtask

   task automatic test_reset_midframe();
      int f0, p0, o0;
      send_frame(8'h21, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      checks++; if (ev_cnt[4] !== 3'd2) begin failures++; $display("FAIL mid_pre_count got=%0d exp=2", ev_cnt[4]); end
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      ser_clk = 1'b0; ser_data = 1'b1;
      #1 reset = 1'b0;
      #1;
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", rx_valid); end
      checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", fifo_count); end
      checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL mid_data got=%h exp=00", rx_data); end
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
      send_frame(8'h5A, 1'b1, 1'b0);
      checks++; if (ev_data[3] !== 8'h5A) begin failures++; $display("FAIL mid_after_data got=%h exp=5a", ev_data[3]); end
      checks++; if (ev_cnt[3] !== 3'd1) begin failures++; $display("FAIL mid_after_count got=%0d exp=1", ev_cnt[3]); end
      checks++; if ((n_ferr - f0) + (n_perr - p0) + (n_ovr - o0) !== 0) begin
         failures++; $display("FAIL mid_after_pulses got=%0d exp=0", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0)); end
      read_expect(8'h5A);
      expect_empty();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_frame_err();
      test_overrun();
      test_back_to_back();
      test_parity();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
